pot_emulator: RTL



---
 rtl/pokey_pkg.sv | 14 +
 rtl/pot_emulator_channel.sv | 40 ++++
 rtl/pot_emulator.sv | 107 ++++++++++
 3 files changed

// File: rtl/pokey_pkg.sv
// Shared constants and state encoding for the paddle RC-network emulator.
package pokey_pkg;

  localparam int MAXCOUNT = 228;
  localparam int NUM_POTS = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DUMP   = 2'd1,
    ST_CHARGE = 2'd2,
    ST_DONE   = 2'd3
  } pot_state_e;

endpackage

// File: rtl/pot_emulator_channel.sv
// One paddle channel: setpoint latched during dump, sticky comparator line
// that drops when the shared scan count meets the setpoint.
module pot_channel
  import pokey_pkg::*;
#(
  parameter int MAXCOUNT = pokey_pkg::MAXCOUNT
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       i_load,
  input  logic       i_release,
  input  logic [7:0] i_pset,
  input  logic [7:0] i_count,
  output logic       o_p
);

  localparam logic [7:0] MAX8 = 8'(MAXCOUNT);

  logic [7:0] r_set;
  logic       r_p;
  logic       w_hit;

  // Setpoints at or beyond the end of the scan never release their line.
  assign w_hit = i_release && (r_set == i_count) && (r_set < MAX8);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_set <= 8'd0;
      r_p   <= 1'b1;
    end else if (i_load) begin
      r_set <= i_pset;
      r_p   <= 1'b1;
    end else if (w_hit) begin
      r_p   <= 1'b0;
    end
  end

  assign o_p = r_p;

endmodule

// File: rtl/pot_emulator.sv
// Board-side stand-in for eight paddles: releases each POKEY pot line at the
// scan tick matching its setpoint, using one shared counter and a small FSM.
module pot_emulator
  import pokey_pkg::*;
#(
  parameter int MAXCOUNT = pokey_pkg::MAXCOUNT
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       enn,
  input  logic       keybClk,
  input  logic       fastScan,
  input  logic       dump,
  input  logic [7:0] pset0,
  input  logic [7:0] pset1,
  input  logic [7:0] pset2,
  input  logic [7:0] pset3,
  input  logic [7:0] pset4,
  input  logic [7:0] pset5,
  input  logic [7:0] pset6,
  input  logic [7:0] pset7,
  output logic [7:0] P,
  output logic       scanDone,
  output pot_state_e o_dbg_state
);

  localparam logic [7:0] MAX8 = 8'(MAXCOUNT);

  pot_state_e r_state;
  pot_state_e w_state_next;
  logic [7:0] r_count;
  logic [7:0] w_count_inc;
  logic [7:0] w_cmp;
  logic       w_tick;
  logic       w_release;
  logic [7:0] w_p;
  logic [7:0] w_pset [NUM_POTS];

  assign w_pset[0] = pset0;
  assign w_pset[1] = pset1;
  assign w_pset[2] = pset2;
  assign w_pset[3] = pset3;
  assign w_pset[4] = pset4;
  assign w_pset[5] = pset5;
  assign w_pset[6] = pset6;
  assign w_pset[7] = pset7;

  assign w_tick      = fastScan ? enn : keybClk;
  assign w_count_inc = (r_count < MAX8) ? r_count + 8'd1 : r_count;
  // The edge leaving DUMP acts as count 0 so zero setpoints release at once.
  assign w_release   = !dump && ((r_state == ST_DUMP) ||
                                 (r_state == ST_CHARGE && w_tick));
  assign w_cmp       = (r_state == ST_DUMP) ? 8'd0 : w_count_inc;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (dump) begin
      w_state_next = ST_DUMP;
    end else begin
      case (r_state)
        ST_IDLE:   w_state_next = ST_IDLE;
        ST_DUMP:   w_state_next = ST_CHARGE;
        ST_CHARGE: if (w_p == 8'h00 || r_count == MAX8) w_state_next = ST_DONE;
        ST_DONE:   w_state_next = ST_DONE;
        default:   w_state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    scanDone    = (r_state == ST_DONE);
    o_dbg_state = r_state;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_count <= 8'd0;
    end else if (dump) begin
      r_count <= 8'd0;
    end else if (r_state == ST_CHARGE && w_tick) begin
      r_count <= w_count_inc;
    end
  end

  for (genvar g = 0; g < NUM_POTS; g++) begin : g_chan
    pot_channel #(.MAXCOUNT(MAXCOUNT)) u_chan (
      .clk       (clk),
      .nreset    (nreset),
      .i_load    (dump),
      .i_release (w_release),
      .i_pset    (w_pset[g]),
      .i_count   (w_cmp),
      .o_p       (w_p[g])
    );
  end

  assign P = w_p;

endmodule
